// File: rtl/serial_adder_pkg.sv
// serial_adder_pkg: shared state encoding, default width and counter sizing
package serial_adder_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, DONE = 2'd2} state_t;
  localparam int DEF_WIDTH = 8;
  function automatic int cnt_w(input int w);
    return $clog2(w + 1);
  endfunction
endpackage

// File: rtl/serial_adder_if.sv
// serial_adder_if: request/result bundle of the serial adder; ovf exists only with SERIAL_ADDER_OVF_EN
interface serial_adder_if #(parameter int WIDTH = serial_adder_pkg::DEF_WIDTH);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;
`ifdef SERIAL_ADDER_OVF_EN
  logic             ovf;
  modport master (output start, a, b, cin, input busy, done, sum, cout, ovf);
  modport slave  (input start, a, b, cin, output busy, done, sum, cout, ovf);
`else
  modport master (output start, a, b, cin, input busy, done, sum, cout);
  modport slave  (input start, a, b, cin, output busy, done, sum, cout);
`endif
endinterface

// File: rtl/fulladder.sv
// fulladder: combinational one-bit full adder cell
module fulladder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);
  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));
endmodule

// File: rtl/serial_adder.sv
// serial_adder: LSB-first bit-serial adder sharing one fulladder over WIDTH cycles.
// Define SERIAL_ADDER_OVF_EN to add the registered signed-overflow output ovf.
module serial_adder import serial_adder_pkg::*; #(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic          clk,
  input  logic          rst_n,
  serial_adder_if.slave bus
);
  localparam int CW = cnt_w(WIDTH);
  state_t           r_state, w_state_nxt;
  logic [WIDTH-1:0] r_a, r_b, r_res, r_sum, w_res_nxt;
  logic [CW-1:0]    r_cnt;
  logic             r_carry, r_cout, r_busy, r_done;
  logic             w_s, w_co, w_accept, w_last;
  fulladder u_fa (.a(r_a[0]), .b(r_b[0]), .cin(r_carry), .sum(w_s), .cout(w_co));
  always_comb begin
    w_accept    = (r_state != SHIFT) && bus.start;
    w_last      = (r_state == SHIFT) && (r_cnt == CW'(WIDTH - 1));
    w_state_nxt = w_accept ? SHIFT : w_last ? DONE : (r_state == SHIFT) ? SHIFT : IDLE;
    w_res_nxt   = {w_s, {(WIDTH-1){1'b0}}} | (r_res >> 1);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_res   <= '0;
      r_sum   <= '0;
      r_cnt   <= '0;
      r_carry <= 1'b0;
      r_cout  <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_busy  <= w_state_nxt == SHIFT;
      r_done  <= w_state_nxt == DONE;
      if (w_accept) begin
        r_a     <= bus.a;
        r_b     <= bus.b;
        r_carry <= bus.cin;
        r_cnt   <= '0;
      end else if (r_state == SHIFT) begin
        r_a     <= r_a >> 1;
        r_b     <= r_b >> 1;
        r_carry <= w_co;
        r_cnt   <= r_cnt + 1'b1;
        r_res   <= w_res_nxt;
      end
      if (w_last) begin
        r_sum  <= w_res_nxt;
        r_cout <= w_co;
      end
    end
  end
`ifdef SERIAL_ADDER_OVF_EN
  logic r_ovf;
  // on the last bit the cell's carry-in is the carry into the MSB
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_ovf <= 1'b0;
    else if (w_last) r_ovf <= r_carry ^ w_co;
  end
  assign bus.ovf = r_ovf;
`endif
  assign bus.busy = r_busy;
  assign bus.done = r_done;
  assign bus.sum  = r_sum;
  assign bus.cout = r_cout;
endmodule

// File: tb/tb_serial_adder.sv
// tb_serial_adder: directed self-checking bench for serial_adder at WIDTH=8
module tb_serial_adder;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_chk = 0;
  int   n_err = 0;
  always #5 clk = ~clk;
  serial_adder_if #(.WIDTH(8)) bus ();
  serial_adder #(.WIDTH(8)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask
  // issues one addition from a negedge; operands switch to na/nb right after the accept edge
  task automatic add(input logic [7:0] ta, input logic [7:0] tb_v, input logic tc,
                     input logic [7:0] na, input logic [7:0] nb, input logic keep,
                     input logic [7:0] es, input logic ec, input string tag);
    logic [7:0] prev;
    int         n, bc;
    logic       held;
    prev = bus.sum;
    n = 0;
    bc = 0;
    held = 1'b1;
    bus.start = 1'b1;
    bus.a = ta;
    bus.b = tb_v;
    bus.cin = tc;
    do begin
      @(negedge clk);
      n++;
      if (n == 1) begin
        bus.start = keep;
        bus.a = na;
        bus.b = nb;
        bus.cin = ~tc;
      end
      if (bus.busy) bc++;
      if (!bus.done && bus.sum !== prev) held = 1'b0;
    end while (!bus.done && n < 40);
    chk({tag, "_lat"}, n, 9);
    chk({tag, "_busy"}, bc, 8);
    chk({tag, "_held"}, held, 1);
    chk({tag, "_sum"}, bus.sum, es);
    chk({tag, "_cout"}, bus.cout, ec);
  endtask
  initial begin
    int d;
    bus.start = 1'b0;
    bus.a = '0;
    bus.b = '0;
    bus.cin = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_sum", bus.sum, 0);
    chk("rst_cout", bus.cout, 0);
    rst_n = 1'b1;
    @(negedge clk);
    add(8'h00, 8'h00, 1'b0, 8'hFF, 8'hFF, 1'b0, 8'h00, 1'b0, "zero");
    @(negedge clk);
    chk("zero_pulse", bus.done, 0);
    add(8'hFF, 8'h01, 1'b0, 8'h00, 8'h00, 1'b0, 8'h00, 1'b1, "wrap");
    @(negedge clk);
    chk("wrap_pulse", bus.done, 0);
    add(8'hA5, 8'h5A, 1'b1, 8'h00, 8'h00, 1'b0, 8'h00, 1'b1, "chain");
    @(negedge clk);
    add(8'h10, 8'h20, 1'b0, 8'h12, 8'h34, 1'b1, 8'h30, 1'b0, "hold");
    add(8'h12, 8'h34, 1'b0, 8'h00, 8'h00, 1'b0, 8'h46, 1'b0, "b2b");
    @(negedge clk);
    chk("b2b_pulse", bus.done, 0);
    bus.start = 1'b1;
    bus.a = 8'h55;
    bus.b = 8'h22;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("mid_busy", bus.busy, 0);
    chk("mid_done", bus.done, 0);
    chk("mid_sum", bus.sum, 0);
    chk("mid_cout", bus.cout, 0);
    @(negedge clk);
    rst_n = 1'b1;
    d = 0;
    repeat (12) begin
      @(negedge clk);
      if (bus.done) d++;
    end
    chk("mid_nodone", d, 0);
    chk("mid_sum_kept", bus.sum, 0);
    add(8'h03, 8'h04, 1'b0, 8'hF0, 8'h0F, 1'b0, 8'h07, 1'b0, "post");
    @(negedge clk);
`ifdef SERIAL_ADDER_OVF_EN
    add(8'h7F, 8'h01, 1'b0, 8'h00, 8'h00, 1'b0, 8'h80, 1'b0, "ovf_pos");
    chk("ovf_pos_ovf", bus.ovf, 1);
    @(negedge clk);
    add(8'hFF, 8'h01, 1'b0, 8'h00, 8'h00, 1'b0, 8'h00, 1'b1, "ovf_neg");
    chk("ovf_neg_ovf", bus.ovf, 0);
    @(negedge clk);
`endif
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
